// File: rtl/an_sel_scanner.sv
// Anode-scan controller for a 4-digit multiplexed 7-segment display.
// A prescaler tick advances a 2-bit digit select; AN is registered alongside sel.

module an_sel_anode #(
  parameter int IDX        = 0,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       Clk,
  input  logic [1:0] sel_nxt,
  output logic       an
);
  // sel_nxt already folds in reset, so this bit resets along with sel.
  always_ff @(posedge Clk)
    an <= (sel_nxt == 2'(IDX)) ^ ACTIVE_LOW;
endmodule

module an_sel_scanner #(
  parameter int REFRESH_DIV   = 4,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [3:0] AN,
  output logic [1:0] sel
);
  localparam int             CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    sel_nxt;

  assign tick = (cnt == LAST);

  always_ff @(posedge Clk) begin
    if (Reset || tick) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  always_comb begin
    sel_nxt = sel;
    if (Reset)     sel_nxt = 2'd0;
    else if (tick) sel_nxt = sel + 2'd1;
  end

  always_ff @(posedge Clk)
    sel <= sel_nxt;

  // Each anode bit is decoded from the same next-state as sel, so AN never skews.
  for (genvar i = 0; i < 4; i++) begin : g_an
    an_sel_anode #(.IDX(i), .ACTIVE_LOW(AN_ACTIVE_LOW)) u_an (
      .Clk     (Clk),
      .sel_nxt (sel_nxt),
      .an      (AN[i])
    );
  end
endmodule

// File: tb/tb_an_sel_scanner.sv
// Bench for an_sel_scanner: three configurations driven by one clock/reset,
// table vectors plus a cycle-count scoreboard and hand-written reset sequences.

module tb_an_sel_scanner;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] an4, an1, anh;
  logic [1:0] sel4, sel1, selh;

  always #10 Clk = ~Clk;

  an_sel_scanner #(.REFRESH_DIV(4), .AN_ACTIVE_LOW(1'b1)) u_div4 (
    .Clk(Clk), .Reset(Reset), .AN(an4), .sel(sel4));
  an_sel_scanner #(.REFRESH_DIV(1), .AN_ACTIVE_LOW(1'b1)) u_div1 (
    .Clk(Clk), .Reset(Reset), .AN(an1), .sel(sel1));
  an_sel_scanner #(.REFRESH_DIV(4), .AN_ACTIVE_LOW(1'b0)) u_hot (
    .Clk(Clk), .Reset(Reset), .AN(anh), .sel(selh));

  typedef struct {
    logic [1:0] s4, s1, sh;
    logic [3:0] a4, a1, ah;
  } exp_t;

  typedef struct {
    bit         rst;
    logic [1:0] sel;
    logic [3:0] an;
    logic [1:0] sel1;
    logic [3:0] anh;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[17];
  int   n_vec = 0;
  int   n_err = 0;
  int   ncyc  = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  // Drive Reset for the coming edge, queue what every DUT must show after it,
  // then pop and compare once the edge has passed.
  task automatic step(input bit rst);
    exp_t e;
    Reset = rst;
    if (rst) ncyc = 0;
    else     ncyc++;
    e.s4 = 2'((ncyc / 4) % 4);
    e.s1 = 2'(ncyc % 4);
    e.sh = e.s4;
    e.a4 = ~(4'b0001 << e.s4);
    e.a1 = ~(4'b0001 << e.s1);
    e.ah = 4'b0001 << e.sh;
    sbq.push_back(e);
    @(posedge Clk);
    #1;
    e = sbq.pop_front();
    chk("div4_sel", {2'b0, sel4}, {2'b0, e.s4});
    chk("div4_an",  an4, e.a4);
    chk("div1_sel", {2'b0, sel1}, {2'b0, e.s1});
    chk("div1_an",  an1, e.a1);
    chk("hot_sel",  {2'b0, selh}, {2'b0, e.sh});
    chk("hot_an",   anh, e.ah);
    chk("div4_onecold", 4'($countones(~an4)), 4'd1);
    chk("div1_onecold", 4'($countones(~an1)), 4'd1);
    chk("hot_onehot",   4'($countones(anh)),  4'd1);
  endtask

  initial begin
    tbl = '{
      '{1'b1, 2'd0, 4'b1110, 2'd0, 4'b0001}, '{1'b0, 2'd0, 4'b1110, 2'd1, 4'b0001},
      '{1'b0, 2'd0, 4'b1110, 2'd2, 4'b0001}, '{1'b0, 2'd0, 4'b1110, 2'd3, 4'b0001},
      '{1'b0, 2'd1, 4'b1101, 2'd0, 4'b0010}, '{1'b0, 2'd1, 4'b1101, 2'd1, 4'b0010},
      '{1'b0, 2'd1, 4'b1101, 2'd2, 4'b0010}, '{1'b0, 2'd1, 4'b1101, 2'd3, 4'b0010},
      '{1'b0, 2'd2, 4'b1011, 2'd0, 4'b0100}, '{1'b0, 2'd2, 4'b1011, 2'd1, 4'b0100},
      '{1'b0, 2'd2, 4'b1011, 2'd2, 4'b0100}, '{1'b0, 2'd2, 4'b1011, 2'd3, 4'b0100},
      '{1'b0, 2'd3, 4'b0111, 2'd0, 4'b1000}, '{1'b0, 2'd3, 4'b0111, 2'd1, 4'b1000},
      '{1'b0, 2'd3, 4'b0111, 2'd2, 4'b1000}, '{1'b0, 2'd3, 4'b0111, 2'd3, 4'b1000},
      '{1'b0, 2'd0, 4'b1110, 2'd0, 4'b0001}
    };

    // Reset edge at 10 ns, then sel changes at 90, 170, 250, 330 ns.
    foreach (tbl[i]) begin
      step(tbl[i].rst);
      chk("tbl_sel",  {2'b0, sel4}, {2'b0, tbl[i].sel});
      chk("tbl_an",   an4,          tbl[i].an);
      chk("tbl_sel1", {2'b0, sel1}, {2'b0, tbl[i].sel1});
      chk("tbl_anh",  anh,          tbl[i].anh);
    end

    // Free-run past 2000 ns.
    for (int i = 0; i < 84; i++) step(1'b0);

    // Reset mid-scan with sel=2, count=2.
    step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("mid_sel_before", {2'b0, sel4}, 4'd2);
    chk("mid_an_before",  an4, 4'b1011);
    step(1'b1);
    chk("mid_sel_rst", {2'b0, sel4}, 4'd0);
    chk("mid_an_rst",  an4, 4'b1110);
    chk("mid_anh_rst", anh, 4'b0001);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0);
      chk("mid_hold_sel", {2'b0, sel4}, 4'd0);
    end
    step(1'b0);
    chk("mid_adv_sel", {2'b0, sel4}, 4'd1);
    chk("mid_adv_an",  an4, 4'b1101);

    // Sporadic resets at arbitrary points of the scan.
    for (int i = 0; i < 200; i++) step($urandom_range(0, 15) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/an_sel_scanner.md
Name: an_sel_scanner

Overview:
- Anode-scan controller for a 4-digit multiplexed 7-segment display.
- A prescaler divides the system clock. On each prescaler tick, a 2-bit digit-select counter advances and cycles 0→1→2→3→0.
- It drives the digit mux select (sel) and the matching active-low anode enable (AN).
- Sits between the system clock and the display mux / segment decoder of the ALU display path.

Parameters:
REFRESH_DIV, 4, clock cycles each digit is held (must be ≥1; set to ~100000 for a 100 Hz-per-digit refresh on hardware; 4 gives visible scanning in short simulations)
AN_ACTIVE_LOW, 1, 1 = AN is one-cold (board default); 0 = AN is one-hot

Ports:
Clk    input   1  system clock, all logic on rising edge
Reset  input   1  synchronous, active-high reset
AN     output  4  digit anode enables, exactly one digit active at any time
sel    output  2  index of the currently active digit, drives the display data mux

Behaviour:
- All state is registered on the rising edge of Clk. There is no asynchronous path.
- Reset is synchronous and active-high. At any edge with Reset=1:
  - prescaler count = 0
  - sel = 2'b00
  - AN = 4'b1110 (AN_ACTIVE_LOW=1) or 4'b0001 (AN_ACTIVE_LOW=0)
- Reset asserted mid-scan returns to this state at the next edge, regardless of count or sel.
- Prescaler:
  - Counter width is max(1, clog2(REFRESH_DIV)).
  - Each non-reset edge: if count == REFRESH_DIV-1, then count ← 0 and a tick fires; otherwise count ← count+1.
  - REFRESH_DIV=1: tick fires on every edge.
- Digit counter:
  - On a tick, sel ← sel+1 modulo 4 (3 wraps to 0).
  - Without a tick, sel holds.
  - Each sel value is held for exactly REFRESH_DIV cycles. The value right after reset also lasts REFRESH_DIV cycles.
- AN decode (AN_ACTIVE_LOW=1): sel 0→1110, 1→1101, 2→1011, 3→0111.
  - AN_ACTIVE_LOW=0 gives the bitwise inverse.
  - AN is a registered output, updated on the same edge as sel, so AN and sel are always consistent. There is no cycle of skew and no glitch.
- Invariants:
  - AN never has zero or more than one active bit.
  - No undefined (X) values on AN or sel after the first reset edge.
- Before the first reset, output values are not required to be defined.
- Full scan period = 4 × REFRESH_DIV cycles.

Test Plan:
1. Clk period 20 ns (edges at 10, 30, 50 ns …), Reset=1 for 0–20 ns, REFRESH_DIV=4 → at 10 ns edge sel=00, AN=1110. Count advances to 3 on the 30, 50 and 70 ns edges; sel stays 00.
2. Same run (continuation of scenario 1) → sel=01/AN=1101 at 90 ns, sel=10/AN=1011 at 170 ns, sel=11/AN=0111 at 250 ns, sel=00/AN=1110 at 330 ns. Pattern repeats every 320 ns up to 2000 ns.
3. Assert Reset for one cycle while sel=10 and count=2 → next edge sel=00, AN=1110, count=0. Next sel change occurs 4 edges after Reset deasserts.
4. REFRESH_DIV=1 → sel steps 00,01,10,11,00 on consecutive edges; AN tracks with one-cold codes every cycle.
5. AN_ACTIVE_LOW=0, REFRESH_DIV=4 → after reset AN=0001, then 0010, 0100, 1000 at the same times as scenario 2.
6. Checker over every cycle after reset → AN has exactly one active bit and matches decode(sel). A sel change occurs every 4 cycles and never otherwise.
